dma_axi_mem_responder: RTL and testbench

- AXI-MM subordinate (responder) backed by on-chip RAM; the other end of the host_mem/ddr_mem initiator ports driven by dma_engine.
- Serves as a loopback/local scratch memory target so dma_engine can be exercised without host or DDR.
- Independent read and write channel FSMs; one burst in flight per channel; INCR bursts only.

---
 rtl/dma_axi_mem_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dma_axi_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_mem_responder.sv
// AXI-MM responder backed by on-chip RAM: local scratch/loopback target for dma_engine.
// Independent read and write FSMs, one INCR burst in flight per channel.
module dma_axi_mem_responder #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 9,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [ID_WIDTH-1:0]     awid,

    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,

    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,

    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [ID_WIDTH-1:0]     arid,

    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [1:0]              rresp,
    output logic                    rlast,

    output logic [15:0]             wlast_err_cnt
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned BYTE_BITS  = $clog2(STRB_WIDTH);

    localparam logic [1:0] W_ADDR  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_ADDR  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Write channel state
    logic [1:0]            wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DEPTH_LOG2-1:0] widx_q, widx_d;
    logic [LEN_WIDTH-1:0]  wlen_q, wlen_d;
    logic [LEN_WIDTH-1:0]  wbeat_q, wbeat_d;
    logic                  werr_q, werr_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  mem_we;

    // Read channel state
    logic [1:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DEPTH_LOG2-1:0] ridx_q, ridx_d;
    logic [LEN_WIDTH-1:0]  rlen_q, rlen_d;
    logic [LEN_WIDTH-1:0]  rbeat_q, rbeat_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Only the word-index slice of each address is meaningful
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        err_cnt_d = err_cnt_q;
        case (wstate_q)
            W_ADDR: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    widx_d    = awaddr[BYTE_BITS +: DEPTH_LOG2];
                    wlen_d    = awlen;
                    bid_d     = awid;
                    wbeat_d   = '0;
                    werr_d    = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // wlast is only checked; the beat count alone ends the burst
                    werr_d = werr_q | (wlast != (wbeat_q == wlen_q));
                    if (wbeat_q == wlen_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = werr_d ? 2'b10 : 2'b00;
                        wstate_d = W_RESP;
                        if (werr_d && (err_cnt_q != 16'hFFFF)) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end else begin
                        wbeat_d = wbeat_q + 1'b1;
                        widx_d  = widx_q + 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_ADDR;
                end
            end
            default: wstate_d = W_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wstate_q  <= W_ADDR;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        case (rstate_q)
            R_ADDR: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    arready_d = 1'b0;
                    ridx_d    = araddr[BYTE_BITS +: DEPTH_LOG2];
                    rlen_d    = arlen;
                    rid_d     = arid;
                    rbeat_d   = '0;
                    rstate_d  = R_FETCH;
                end
            end
            R_FETCH: begin
                rvalid_d = 1'b1;
                rlast_d  = (rbeat_q == rlen_q);
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (rready && rvalid_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        rstate_d  = R_ADDR;
                    end else begin
                        rbeat_d  = rbeat_q + 1'b1;
                        ridx_d   = ridx_q + 1'b1;
                        rstate_d = R_FETCH;
                    end
                end
            end
            default: rstate_d = R_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rstate_q  <= R_ADDR;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
        end
    end

    assign mem_we = reset_n && (wstate_q == W_DATA) && wvalid && wready_q;

    // No reset on the array or read register so this maps onto block RAM;
    // a same-word read and write in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) begin
                    mem[widx_q][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (rstate_q == R_FETCH) begin
            rdata_q <= mem[ridx_q];
        end
    end

    assign awready       = awready_q;
    assign wready        = wready_q;
    assign bvalid        = bvalid_q;
    assign bid           = bid_q;
    assign bresp         = bresp_q;
    assign arready       = arready_q;
    assign rvalid        = rvalid_q;
    assign rdata         = rdata_q;
    assign rid           = rid_q;
    assign rresp         = 2'b00;
    assign rlast         = rlast_q;
    assign wlast_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dma_axi_mem_responder.sv
// Directed bench for dma_axi_mem_responder at default parameters (512-bit data, 1024 words).
module tb_dma_axi_mem_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [8:0]   awid;
    logic         wvalid, wready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         bvalid, bready;
    logic [8:0]   bid;
    logic [1:0]   bresp;
    logic         arvalid, arready;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [8:0]   arid;
    logic         rvalid, rready;
    logic [511:0] rdata;
    logic [8:0]   rid;
    logic [1:0]   rresp;
    logic         rlast;
    logic [15:0]  wlast_err_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dma_axi_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp),
        .rlast(rlast), .wlast_err_cnt(wlast_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [63:0] a, input logic [7:0] l, input logic [8:0] id);
        int n = 0;
        awaddr = a; awlen = l; awid = id; awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        check_n("aw_ready", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [511:0] d, input logic [63:0] s, input logic last);
        int n = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 50) begin tick(); n++; end
        check_n("w_ready", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp, input logic [8:0] id);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin tick(); n++; end
        check_n("b_valid", 32'(bvalid), 32'd1);
        check_n("b_resp", 32'(bresp), 32'(resp));
        check_n("b_id", 32'(bid), 32'(id));
        tick();
        bready = 1'b0;
    endtask

    // Address handshake, then rvalid must be low one cycle and high the next
    task automatic do_ar(input logic [63:0] a, input logic [7:0] l, input logic [8:0] id);
        int n = 0;
        araddr = a; arlen = l; arid = id; arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        check_n("ar_ready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check_n("r_fetch_gap", 32'(rvalid), 32'd0);
        tick();
        check_n("r_latency", 32'(rvalid), 32'd1);
    endtask

    task automatic do_r(input logic [511:0] d, input logic last, input logic [8:0] id);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < 50) begin tick(); n++; end
        check_n("r_valid", 32'(rvalid), 32'd1);
        check_w("r_data", rdata, d);
        check_n("r_last", 32'(rlast), 32'(last));
        check_n("r_id", 32'(rid), 32'(id));
        check_n("r_resp", 32'(rresp), 32'd0);
        tick();
        rready = 1'b0;
    endtask

    localparam logic [63:0] ALL_STRB = '1;

    initial begin
        reset_n = 1'b0;
        awvalid = 1'b0; awaddr = '0; awlen = '0; awid = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arlen = '0; arid = '0;
        rready = 1'b0;
        tick(); tick(); tick();

        // Reset values
        check_n("rst_awready", 32'(awready), 32'd0);
        check_n("rst_arready", 32'(arready), 32'd0);
        check_n("rst_wready", 32'(wready), 32'd0);
        check_n("rst_bvalid", 32'(bvalid), 32'd0);
        check_n("rst_rvalid", 32'(rvalid), 32'd0);
        check_n("rst_rlast", 32'(rlast), 32'd0);
        check_n("rst_bresp_bid", 32'({bresp, bid}), 32'd0);
        check_n("rst_rresp_rid", 32'({rresp, rid}), 32'd0);
        check_n("rst_errcnt", 32'(wlast_err_cnt), 32'd0);
        reset_n = 1'b1;
        tick();
        check_n("post_rst_awready", 32'(awready), 32'd1);
        check_n("post_rst_arready", 32'(arready), 32'd1);

        // Single-beat write and read at 0x40
        do_aw(64'h40, 8'd0, 9'h055);
        do_w({64{8'hA5}}, ALL_STRB, 1'b1);
        do_b(2'b00, 9'h055);
        do_ar(64'h40, 8'd0, 9'h123);
        do_r({64{8'hA5}}, 1'b1, 9'h123);

        // 8-beat burst from word 1020 wrapping to word 3
        do_aw(64'd1020 * 64, 8'd7, 9'h0A0);
        for (int i = 0; i < 8; i++) do_w(512'(i), ALL_STRB, i == 7);
        do_b(2'b00, 9'h0A0);
        do_ar(64'd1020 * 64, 8'd7, 9'h0B0);
        for (int i = 0; i < 8; i++) do_r(512'(i), i == 7, 9'h0B0);
        do_ar(64'h0, 8'd0, 9'h001);
        do_r(512'd4, 1'b1, 9'h001);

        // Byte strobes at word 64
        do_aw(64'h1000, 8'd0, 9'h010);
        do_w({64{8'hFF}}, ALL_STRB, 1'b1);
        do_b(2'b00, 9'h010);
        do_aw(64'h1000, 8'd0, 9'h011);
        do_w('0, 64'h1, 1'b1);
        do_b(2'b00, 9'h011);
        do_ar(64'h1000, 8'd0, 9'h012);
        do_r({{63{8'hFF}}, 8'h00}, 1'b1, 9'h012);

        // wlast asserted on beat 1 of 4: all beats taken, SLVERR, one count
        do_aw(64'h2000, 8'd3, 9'h020);
        for (int i = 0; i < 4; i++) do_w({64{8'hC0}} | 512'(i), ALL_STRB, i == 1);
        do_b(2'b10, 9'h020);
        check_n("errcnt_one", 32'(wlast_err_cnt), 32'd1);
        do_aw(64'h2000, 8'd1, 9'h021);
        do_w(512'h11, ALL_STRB, 1'b0);
        do_w(512'h22, ALL_STRB, 1'b1);
        do_b(2'b00, 9'h021);
        check_n("errcnt_stays", 32'(wlast_err_cnt), 32'd1);
        do_ar(64'h2000, 8'd3, 9'h022);
        do_r(512'h11, 1'b0, 9'h022);
        do_r(512'h22, 1'b0, 9'h022);
        do_r({64{8'hC0}} | 512'd2, 1'b0, 9'h022);
        do_r({64{8'hC0}} | 512'd3, 1'b1, 9'h022);

        // Backpressure on B
        do_aw(64'd100 * 64, 8'd0, 9'h1AA);
        do_w({64{8'h5A}}, ALL_STRB, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check_n("bp_bvalid", 32'(bvalid), 32'd1);
        check_n("bp_bid", 32'(bid), 32'h1AA);
        check_n("bp_awready", 32'(awready), 32'd0);
        do_b(2'b00, 9'h1AA);

        // Backpressure on R mid-burst
        do_ar(64'd1020 * 64, 8'd2, 9'h0C0);
        do_r(512'd0, 1'b0, 9'h0C0);
        for (int i = 0; i < 5; i++) tick();
        check_n("bp_rvalid", 32'(rvalid), 32'd1);
        check_w("bp_rdata", rdata, 512'd1);
        check_n("bp_rlast", 32'(rlast), 32'd0);
        do_r(512'd1, 1'b0, 9'h0C0);
        do_r(512'd2, 1'b1, 9'h0C0);
        do_ar(64'd100 * 64, 8'd0, 9'h0C1);
        do_r({64{8'h5A}}, 1'b1, 9'h0C1);

        // Reset after two of four write beats
        do_aw(64'd200 * 64, 8'd3, 9'h0D0);
        do_w({64{8'hB0}}, ALL_STRB, 1'b0);
        do_w({64{8'hB1}}, ALL_STRB, 1'b0);
        reset_n = 1'b0;
        tick();
        check_n("mid_rst_wready", 32'(wready), 32'd0);
        check_n("mid_rst_awready", 32'(awready), 32'd0);
        check_n("mid_rst_arready", 32'(arready), 32'd0);
        check_n("mid_rst_valids", 32'({bvalid, rvalid}), 32'd0);
        reset_n = 1'b1;
        tick();
        check_n("mid_rst_release", 32'(awready), 32'd1);
        do_ar(64'd200 * 64, 8'd1, 9'h0D1);
        do_r({64{8'hB0}}, 1'b0, 9'h0D1);
        do_r({64{8'hB1}}, 1'b1, 9'h0D1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
